// File: rtl/vrf_rd_seq_pkg.sv
// rtl/vrf_rd_seq_pkg.sv - shared types for the VRF read sequencer
package gatlingPkg;

  // Tag mask is sized for the widest supported bank count; users take the low BANK_COUNT bits.
  localparam int TAG_MASK_W = 16;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_ISSUE,
    RD_DRAIN
  } rdSeqState_t;

  typedef struct packed {
    logic                  valid;
    logic [TAG_MASK_W-1:0] mask;
    logic                  last;
  } rdSeqTag_t;

  function automatic int bankAddrWidth(input int addrWidth, input int bankCount);
    return addrWidth - $clog2(bankCount);
  endfunction

endpackage

// File: rtl/vrf_rd_seq_tagDelay.sv
// rtl/vrf_rd_seq_tagDelay.sv - fixed-depth tag shift register with hold and clear
module tagDelay
  import gatlingPkg::*;
#(
  parameter int DEPTH = 5
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      hold,
  input  rdSeqTag_t inTag,
  output rdSeqTag_t headTag,
  output logic      anyValid
);

  rdSeqTag_t stages [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
    end else if (!hold) begin
      stages[0] <= inTag;
      for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

  always_comb begin
    anyValid = 1'b0;
    for (int i = 0; i < DEPTH; i++) anyValid = anyValid | stages[i].valid;
  end

  assign headTag = stages[DEPTH-1];

endmodule

// File: rtl/vrf_rd_seq.sv
// rtl/vrf_rd_seq.sv - vector-read sequencer driving the banked VRF read port
module vrf_rd_seq
  import gatlingPkg::*;
#(
  parameter int ADDR_WIDTH      = 7,
  parameter int BANK_COUNT      = 4,
  parameter int VL_WIDTH        = 8,
  parameter int RD_LATENCY      = 5,
  parameter int ENABLE_STALLING = 0
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              stall,
  input  logic                                              cmdValid,
  output logic                                              cmdReady,
  input  logic [bankAddrWidth(ADDR_WIDTH, BANK_COUNT)-1:0]  cmdBaseRow,
  input  logic [VL_WIDTH-1:0]                               cmdVl,
  output logic [bankAddrWidth(ADDR_WIDTH, BANK_COUNT)-1:0]  rdAddr,
  output logic                                              rdAddrValid,
  output logic                                              outValid,
  output logic [BANK_COUNT-1:0]                             outMask,
  output logic                                              outLast,
  output logic                                              done
);

  localparam int BAW   = bankAddrWidth(ADDR_WIDTH, BANK_COUNT);
  localparam int LOG2B = $clog2(BANK_COUNT);

  rdSeqState_t          state;
  logic [VL_WIDTH:0]    rowsLeft;
  logic [LOG2B-1:0]     tailCnt;
  logic [BAW-1:0]       addrQ;
  logic                 addrValidQ;
  logic                 stallEff;
  logic                 accept;
  logic                 issueNow;
  logic                 lastRow;
  logic                 lineBusy;
  logic [VL_WIDTH:0]    vlRounded;
  logic [BANK_COUNT-1:0] rowMask;
  rdSeqTag_t            pushTag;
  rdSeqTag_t            headTag;
  logic                 unusedMaskHi;

  assign stallEff  = (ENABLE_STALLING != 0) && stall;
  assign cmdReady  = (state == RD_IDLE) && !rst && !stallEff;
  assign accept    = cmdValid && cmdReady;
  assign issueNow  = (state == RD_ISSUE) && !stallEff;
  assign lastRow   = (rowsLeft == (VL_WIDTH+1)'(1));
  // Extra carry bit keeps ceil() exact for vl near 2^VL_WIDTH.
  assign vlRounded = ({1'b0, cmdVl} + (VL_WIDTH+1)'(BANK_COUNT-1)) >> LOG2B;

  always_comb begin
    rowMask = '1;
    if (lastRow && (tailCnt != '0)) rowMask = ~({BANK_COUNT{1'b1}} << tailCnt);
  end

  always_comb begin
    pushTag       = '0;
    pushTag.valid = issueNow;
    pushTag.mask  = issueNow ? TAG_MASK_W'(rowMask) : '0;
    pushTag.last  = issueNow && lastRow;
  end

  // addrQ doubles as the row pointer; it stays on the final row once issue ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RD_IDLE;
      rowsLeft   <= '0;
      tailCnt    <= '0;
      addrQ      <= '0;
      addrValidQ <= 1'b0;
    end else if (!stallEff) begin
      case (state)
        RD_IDLE: begin
          if (accept) begin
            rowsLeft   <= vlRounded;
            tailCnt    <= cmdVl[LOG2B-1:0];
            addrQ      <= cmdBaseRow;
            addrValidQ <= (cmdVl != '0);
            state      <= (cmdVl != '0) ? RD_ISSUE : RD_DRAIN;
          end
        end
        RD_ISSUE: begin
          rowsLeft <= rowsLeft - 1'b1;
          if (lastRow) begin
            state      <= RD_DRAIN;
            addrValidQ <= 1'b0;
          end else begin
            addrQ <= addrQ + 1'b1;
          end
        end
        RD_DRAIN: begin
          if (!lineBusy) state <= RD_IDLE;
        end
        default: state <= RD_IDLE;
      endcase
    end
  end

  tagDelay #(
    .DEPTH(RD_LATENCY)
  ) uTagDelay (
    .clk     (clk),
    .rst     (rst),
    .hold    (stallEff),
    .inTag   (pushTag),
    .headTag (headTag),
    .anyValid(lineBusy)
  );

  assign rdAddr       = addrQ;
  assign rdAddrValid  = addrValidQ;
  assign outValid     = headTag.valid;
  assign outMask      = headTag.mask[BANK_COUNT-1:0];
  assign outLast      = headTag.last;
  assign done         = (state == RD_DRAIN) && !lineBusy && !stallEff && !rst;
  assign unusedMaskHi = ^(headTag.mask >> BANK_COUNT);

endmodule

// File: tb/tb_vrf_rd_seq.sv
// tb/tb_vrf_rd_seq.sv - self-checking bench for vrf_rd_seq
module tb_vrf_rd_seq;

  localparam int LAT   = 5;
  localparam int BANKS = 4;
  localparam int NROWS = 32;
  localparam int NRND  = 14;
  localparam int ESZ   = 1024;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       stall = 1'b0, sStall = 1'b0;
  logic       cmdValid = 1'b0;
  logic [4:0] cmdBaseRow = '0;
  logic [7:0] cmdVl = '0;

  logic       cmdReady, rdAddrValid, outValid, outLast, done;
  logic [4:0] rdAddr;
  logic [3:0] outMask;
  logic       sReady, sRav, sOutValid, sOutLast, sDone;
  logic [4:0] sAddr;
  logic [3:0] sOutMask;

  vrf_rd_seq #(.ENABLE_STALLING(0)) dut (
    .clk(clk), .rst(rst), .stall(stall), .cmdValid(cmdValid), .cmdReady(cmdReady),
    .cmdBaseRow(cmdBaseRow), .cmdVl(cmdVl), .rdAddr(rdAddr), .rdAddrValid(rdAddrValid),
    .outValid(outValid), .outMask(outMask), .outLast(outLast), .done(done)
  );

  vrf_rd_seq #(.ENABLE_STALLING(1)) dutS (
    .clk(clk), .rst(rst), .stall(sStall), .cmdValid(cmdValid), .cmdReady(sReady),
    .cmdBaseRow(cmdBaseRow), .cmdVl(cmdVl), .rdAddr(sAddr), .rdAddrValid(sRav),
    .outValid(sOutValid), .outMask(sOutMask), .outLast(sOutLast), .done(sDone)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nCmp = 0;
  int nBad = 0;

  task automatic check(input string name, input longint act, input longint req);
    nCmp++;
    if (act != req) begin
      nBad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  typedef struct {
    logic [7:0] vl;
    logic [4:0] base;
    int rows;
    int firstAddr;
    int lastAddr;
    int lastMask;
    int doneOff;
  } vec_t;

  vec_t vecs [7];

  task automatic runVec(input string tag, input vec_t v);
    int nIss, firstA, lastA, firstIssOff, nOut, firstOutOff, nLastFlag, lastM, badMask;
    int nDone, doneOff, readyOff;
    nIss = 0; firstA = -1; lastA = -1; firstIssOff = -1; nOut = 0; firstOutOff = -1;
    nLastFlag = 0; lastM = -1; badMask = 0; nDone = 0; doneOff = -1; readyOff = -1;
    @(posedge clk); #1;
    cmdVl = v.vl; cmdBaseRow = v.base; cmdValid = 1'b1;
    @(negedge clk);
    check({tag, "_ready"}, cmdReady, 1);
    @(posedge clk); #1;
    cmdValid = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      @(negedge clk);
      if (rdAddrValid) begin
        if (firstA < 0) begin firstA = rdAddr; firstIssOff = k; end
        lastA = rdAddr;
        nIss++;
      end
      if (outValid) begin
        nOut++;
        if (firstOutOff < 0) firstOutOff = k;
        if (outLast) begin nLastFlag++; lastM = outMask; end
        else if (outMask != 4'hf) badMask++;
      end
      if (done) begin nDone++; if (doneOff < 0) doneOff = k; end
      if (cmdReady && readyOff < 0) readyOff = k;
    end
    check({tag, "_issued"}, nIss, v.rows);
    check({tag, "_firstAddr"}, firstA, v.firstAddr);
    check({tag, "_lastAddr"}, lastA, v.lastAddr);
    check({tag, "_firstIssueOff"}, firstIssOff, (v.rows > 0) ? 1 : -1);
    check({tag, "_outRows"}, nOut, v.rows);
    check({tag, "_firstOutOff"}, firstOutOff, (v.rows > 0) ? 1 + LAT : -1);
    check({tag, "_lastFlags"}, nLastFlag, (v.rows > 0) ? 1 : 0);
    check({tag, "_lastMask"}, lastM, v.lastMask);
    check({tag, "_fullMasks"}, badMask, 0);
    check({tag, "_doneOff"}, doneOff, v.doneOff);
    check({tag, "_donePulses"}, nDone, 1);
    check({tag, "_readyOff"}, readyOff, v.doneOff + 1);
  endtask

  // Reference model for the random phase: expected per-cycle outputs relative to first accept.
  logic eAcc [ESZ], eRav [ESZ], eOv [ESZ], eLast [ESZ], eDone [ESZ];
  int   eAddr [ESZ], eMask [ESZ];
  int   accRel [NRND];
  logic [7:0] rVl [NRND];
  logic [4:0] rBase [NRND];
  bit   rndOn = 1'b0;
  int   rT0 = 0;
  int   rSpan = 0;

  always @(negedge clk) begin
    int i;
    if (rndOn) begin
      i = cyc - rT0;
      if (i >= 0 && i <= rSpan) begin
        check($sformatf("rnd_accept@%0d", i), cmdValid && cmdReady, eAcc[i]);
        check($sformatf("rnd_rdAddrValid@%0d", i), rdAddrValid, eRav[i]);
        if (eRav[i]) check($sformatf("rnd_rdAddr@%0d", i), rdAddr, eAddr[i]);
        check($sformatf("rnd_outValid@%0d", i), outValid, eOv[i]);
        if (eOv[i]) begin
          check($sformatf("rnd_outMask@%0d", i), outMask, eMask[i]);
          check($sformatf("rnd_outLast@%0d", i), outLast, eLast[i]);
        end
        check($sformatf("rnd_done@%0d", i), done, eDone[i]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sOutCnt, sDoneOff, doneOff, t, r, tail, target;

    vecs[0] = '{8'd8,   5'd3,  2,  3,  4, 15,  8};
    vecs[1] = '{8'd6,   5'd31, 2, 31,  0,  3,  8};
    vecs[2] = '{8'd0,   5'd7,  0, -1, -1, -1,  1};
    vecs[3] = '{8'd1,   5'd0,  1,  0,  0,  1,  7};
    vecs[4] = '{8'd13,  5'd30, 4, 30,  1,  1, 10};
    vecs[5] = '{8'd255, 5'd10, 64, 10, 9,  7, 70};
    vecs[6] = '{8'd4,   5'd9,  1,  9,  9, 15,  7};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cmdReady", cmdReady, 0);
    check("rst_rdAddr", rdAddr, 0);
    check("rst_rdAddrValid", rdAddrValid, 0);
    check("rst_outValid", outValid, 0);
    check("rst_outMask", outMask, 0);
    check("rst_outLast", outLast, 0);
    check("rst_done", done, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_cmdReady", cmdReady, 1);
    check("post_rst_sReady", sReady, 1);

    for (int n = 0; n < 6; n++) runVec($sformatf("vec%0d", n), vecs[n]);

    // Stall: dutS honours it, dut ignores the same pattern
    sOutCnt = 0; sDoneOff = -1; doneOff = -1;
    @(posedge clk); #1;
    cmdVl = 8'd12; cmdBaseRow = 5'd5; cmdValid = 1'b1;
    @(negedge clk);
    check("stall_accept", sReady, 1);
    @(posedge clk); #1;
    cmdValid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      stall = (k == 2 || k == 3 || k == 13);
      sStall = stall;
      @(negedge clk);
      if (k >= 2 && k <= 4) begin
        check($sformatf("stall_holdAddr@%0d", k), sAddr, 6);
        check($sformatf("stall_holdValid@%0d", k), sRav, 1);
      end
      if (k == 5) check("stall_row2Addr", sAddr, 7);
      if (k == 2 || k == 3) check($sformatf("stall_busyReady@%0d", k), sReady, 0);
      if (k == 12) check("stall_readyBack", sReady, 1);
      if (k == 13) begin
        check("stall_idleReadyForced", sReady, 0);
        check("nostall_idleReady", cmdReady, 1);
      end
      if (sOutValid) sOutCnt++;
      if (sDone && sDoneOff < 0) sDoneOff = k;
      if (done && doneOff < 0) doneOff = k;
    end
    stall = 1'b0; sStall = 1'b0;
    check("stall_doneOff", sDoneOff, 11);
    check("stall_outRows", sOutCnt, 3);
    check("nostall_doneOff", doneOff, 9);

    // Mid-command reset
    @(posedge clk); #1;
    cmdVl = 8'd16; cmdBaseRow = 5'd0; cmdValid = 1'b1;
    @(negedge clk);
    check("abort_accept", cmdReady, 1);
    @(posedge clk); #1; cmdValid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("abort_rdAddr", rdAddr, 0);
    check("abort_rdAddrValid", rdAddrValid, 0);
    check("abort_outValid", outValid, 0);
    check("abort_outMask", outMask, 0);
    check("abort_outLast", outLast, 0);
    check("abort_cmdReady", cmdReady, 1);
    doneOff = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) doneOff++;
    end
    check("abort_noDone", doneOff, 0);
    runVec("afterAbort", vecs[6]);

    // Random back-to-back with cmdValid held high
    for (int i = 0; i < ESZ; i++) begin
      eAcc[i] = 0; eRav[i] = 0; eOv[i] = 0; eLast[i] = 0; eDone[i] = 0; eAddr[i] = 0; eMask[i] = 0;
    end
    t = 0;
    for (int n = 0; n < NRND; n++) begin
      rVl[n]   = (n == 3) ? 8'd0 : 8'($urandom_range(0, 40));
      rBase[n] = 5'($urandom_range(0, NROWS - 1));
      r    = (int'(rVl[n]) + BANKS - 1) / BANKS;
      tail = int'(rVl[n]) % BANKS;
      accRel[n] = t;
      eAcc[t] = 1;
      for (int k = 0; k < r; k++) begin
        eRav[t + 1 + k]  = 1;
        eAddr[t + 1 + k] = (int'(rBase[n]) + k) % NROWS;
        eOv[t + 1 + k + LAT]   = 1;
        eLast[t + 1 + k + LAT] = (k == r - 1);
        eMask[t + 1 + k + LAT] = (k == r - 1 && tail != 0) ? (1 << tail) - 1 : 15;
      end
      // An empty command completes on the next cycle; otherwise after its rows drain.
      eDone[(r == 0) ? t + 1 : t + r + LAT + 1] = 1;
      rSpan = (r == 0) ? t + 2 : t + r + LAT + 2;
      t = rSpan;
    end
    @(posedge clk); #1;
    rT0 = cyc;
    cmdVl = rVl[0]; cmdBaseRow = rBase[0]; cmdValid = 1'b1;
    rndOn = 1'b1;
    for (int n = 1; n <= NRND; n++) begin
      target = rT0 + accRel[n-1] + 1;
      while (cyc < target) begin @(posedge clk); #1; end
      if (n < NRND) begin cmdVl = rVl[n]; cmdBaseRow = rBase[n]; end
      else cmdValid = 1'b0;
    end
    while (cyc <= rT0 + rSpan + 1) begin @(posedge clk); #1; end
    rndOn = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule

// File: doc/vrf_rd_seq.md
# vrf_rd_seq

Read sequencer for the banked vector register file. Accepts one vector-read command at a time and issues one row address per cycle into the VRF `rdAddr` port. It generates the per-row element mask and last flag, delays them to line up with `rdData` at the VRF output, and pulses `done` when the final row has left the read pipeline. It sits between the issue stage and the `gatlingVRF` read side, and follows its stall semantics.

## Interface
Parameters:
- `ADDR_WIDTH`, 7: full VRF element address width.
- `BANK_COUNT`, 4: number of banks, which is also the elements per row; power of two.
- `VL_WIDTH`, 8: width of the vector-length field.
- `RD_LATENCY`, 5: cycles from `rdAddr` issue to aligned `rdData`; equals `BANK_COUNT`+1.
- `ENABLE_STALLING`, 0: when 1, `stall` freezes all state.

Ports (`BAW` = `ADDR_WIDTH`-$clog2(`BANK_COUNT`)):
- `clk`, in, 1: sole clock; all state updates on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `stall`, in, 1: global pipeline stall; honoured only when `ENABLE_STALLING`=1.
- `cmdValid`, in, 1: command present.
- `cmdReady`, out, 1: sequencer can accept a command.
- `cmdBaseRow`, in, `BAW`: first row address.
- `cmdVl`, in, `VL_WIDTH`: element count.
- `rdAddr`, out, `BAW`: row address driven into the VRF.
- `rdAddrValid`, out, 1: `rdAddr` carries a live row this cycle.
- `outValid`, out, 1: VRF `rdData` this cycle belongs to the command.
- `outMask`, out, `BANK_COUNT`: active elements of that row.
- `outLast`, out, 1: that row is the final row.
- `done`, out, 1: one-cycle pulse when the command completes.

## Operation
- FSM has three states: IDLE, ISSUE, DRAIN. Reset state is IDLE.
- `cmdReady` = (state==IDLE) && !rst.
- Accept happens on `cmdValid`&&`cmdReady`. On accept:
  - latch `rowsLeft` = ceil(`cmdVl`/`BANK_COUNT`);
  - latch `tailCnt` = `cmdVl` mod `BANK_COUNT`;
  - load the row pointer with `cmdBaseRow`.
- IDLE -> ISSUE on accept with `cmdVl`!=0. IDLE -> DRAIN on accept with `cmdVl`==0; nothing is issued and the pipe is already empty.
- In ISSUE, each non-stalled cycle does the following:
  - drive `rdAddr` = pointer and `rdAddrValid`=1;
  - increment the pointer modulo 2^`BAW` (wraps from all-ones to 0);
  - decrement `rowsLeft`;
  - push {1, mask, last} into a `RD_LATENCY`-deep delay line.
- mask is all ones except on the last row. On the last row, mask = low `tailCnt` bits set, or all ones if `tailCnt`==0.
- ISSUE -> DRAIN after the row with `rowsLeft`==1 is issued.
- In DRAIN, the delay line shifts in zeros. DRAIN -> IDLE when the delay line is empty; `done` is asserted in the same cycle as that transition.
- The delay-line head drives `outValid`/`outMask`/`outLast`.
- When not issuing, `rdAddr` holds its last value and `rdAddrValid`=0.
- Stall (`ENABLE_STALLING`&&`stall`) freezes FSM, pointer, counters and delay line. `cmdReady` is forced to 0, and `done` cannot fire.
- Stall with `ENABLE_STALLING`=0 is ignored entirely.
- Mid-operation `rst` aborts the command. The next cycle is IDLE with the delay line cleared; no `done` pulse.
- A new command cannot overlap the drain of the previous one; back-to-back gap is `RD_LATENCY`+1 cycles minimum.

## Timing
- Reset values: `cmdReady`=0 during `rst`, 1 from the first cycle after. `rdAddr`=0, `rdAddrValid`=0, `outValid`=0, `outMask`=0, `outLast`=0, `done`=0.
- Accept at cycle T (unstalled): row k issues at T+1+k, and its `outValid` is at T+1+k+`RD_LATENCY`.
- For R rows, `done` is at T+R+`RD_LATENCY`+1, and `cmdReady` returns at T+R+`RD_LATENCY`+2.
- `cmdVl`==0: `done` at T+1.
- Every stalled cycle adds exactly one cycle to all subsequent events.

## Structure
- Shared package `gatlingPkg`: `BANK_ADDR_WIDTH` derivation function, FSM state enum `rdSeqState_t`, and the delay-line entry struct `rdSeqTag_t` {valid, mask, last}.
- One sub-module, `tagDelay`: a parameterised depth-N shift register with stall-hold and synchronous clear, holding `rdSeqTag_t`.
- Row/tail arithmetic uses `VL_WIDTH`-bit unsigned values. ceil is computed as (vl + `BANK_COUNT`-1) >> log2(`BANK_COUNT`), with one extra carry bit.

## Test plan
- `cmdVl`=8, base=3, defaults -> `rdAddr` 3,4 at T+1, T+2; `outValid` at T+6, T+7; masks 1111,1111; `outLast` on the second; `done` at T+8.
- `cmdVl`=6, base=31 (`BAW`=5) -> `rdAddr` 31 then 0 (wrap); last mask 0011.
- `cmdVl`=0 -> no `rdAddrValid`, no `outValid`; `done` at T+1; `cmdReady` at T+2.
- `ENABLE_STALLING`=1, `cmdVl`=12, `stall` high at T+2 and T+3 -> `rdAddr` holds row 1 for three cycles; `done` at T+11 (nominal T+9); `cmdReady`=0 during the stall.
- `rst` pulsed at T+3 during `cmdVl`=16 -> all outputs 0 next cycle, no `done`; a fresh `cmdVl`=4 then completes normally with mask 1111.
- Random back-to-back commands with `cmdValid` held high -> accept spacing is exactly R+`RD_LATENCY`+2 cycles; scoreboard matches every row's mask and last flag.
